i2c_slave_edge_filter: RTL and testbench

//  Conditions one open-drain I2C line (SCL or SDA) for the I2C slave controller.
//  It synchronises the raw line to clk and rejects glitches with a consensus filter.
//  It outputs the filtered level plus single-cycle rising/falling edge strobes.
//  The slave instantiates two copies, one for SCL and one for SDA.
//  It derives START = ne(SDA) & fsig(SCL) and STOP = pe(SDA) & fsig(SCL).

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_slave_edge_filter_if.sv | 14 +
 rtl/i2c_sync_chain.sv | 24 ++
 rtl/i2c_slave_edge_filter.sv | 80 ++++++++
 tb/tb_i2c_slave_edge_filter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C front-end constants.
package i2c_pkg;

    // Default depth of the metastability synchroniser.
    localparam int unsigned I2C_SYNC_STAGES_DEF = 2;
    // Default number of equal synchronised samples needed to change the filtered level.
    localparam int unsigned I2C_FILTER_LEN_DEF  = 4;

endpackage

// File: rtl/i2c_slave_edge_filter_if.sv
// One conditioned I2C line: raw level in, filtered level and edge strobes out.
interface i2c_slave_edge_filter_if;

    logic sig;
    logic fsig;
    logic ne;
    logic pe;

    // Bus side (drives the raw line, watches the conditioned outputs).
    modport master (output sig, input fsig, input ne, input pe);
    // Filter side.
    modport slave  (input sig, output fsig, output ne, output pe);

endinterface

// File: rtl/i2c_sync_chain.sv
// N-flop synchroniser; resets to 1 so a released (idle) bus is assumed.
module i2c_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw level through the chain; bit 0 takes the asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/i2c_slave_edge_filter.sv
// Synchronises and consensus-filters one I2C line, producing registered level and edge strobes.
module i2c_slave_edge_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = I2C_SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN  = I2C_FILTER_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    i2c_slave_edge_filter_if.slave  bus
);

    logic                  w_s_out;
    logic [FILTER_LEN-2:0] r_hist;
    logic [FILTER_LEN-1:0] w_window;
    logic                  w_all_one;
    logic                  w_all_zero;

    logic r_fsig;
    logic r_ne;
    logic r_pe;
    logic w_fsig_d;
    logic w_ne_d;
    logic w_pe_d;

    i2c_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.sig),
        .o_q   (w_s_out)
    );

    // Newest sample sits in bit 0; slicing the window keeps FILTER_LEN = 2 legal.
    assign w_window   = {r_hist, w_s_out};
    assign w_all_one  = &w_window;
    assign w_all_zero = ~|w_window;

    // History of past synchroniser outputs, idle-high after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '1;
        end else begin
            r_hist <= w_window[FILTER_LEN-2:0];
        end
    end

    // Consensus decision: move the level only on a unanimous window, strobing the direction.
    always_comb begin
        w_fsig_d = r_fsig;
        w_ne_d   = 1'b0;
        w_pe_d   = 1'b0;
        if (w_all_one && !r_fsig) begin
            w_fsig_d = 1'b1;
            w_pe_d   = 1'b1;
        end else if (w_all_zero && r_fsig) begin
            w_fsig_d = 1'b0;
            w_ne_d   = 1'b1;
        end
    end

    // Output registers; reset forces idle-high with no strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsig <= 1'b1;
            r_ne   <= 1'b0;
            r_pe   <= 1'b0;
        end else begin
            r_fsig <= w_fsig_d;
            r_ne   <= w_ne_d;
            r_pe   <= w_pe_d;
        end
    end

    assign bus.fsig = r_fsig;
    assign bus.ne   = r_ne;
    assign bus.pe   = r_pe;

endmodule

// File: tb/tb_i2c_slave_edge_filter.sv
// Bench for the I2C line filter: SCL and SDA instances checked each cycle against a sample-queue model.
module tb_i2c_slave_edge_filter;
    import i2c_pkg::*;

    localparam int unsigned SyncStages = I2C_SYNC_STAGES_DEF;
    localparam int unsigned FilterLen  = I2C_FILTER_LEN_DEF;
    localparam int unsigned Lat        = SyncStages + FilterLen;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    i2c_slave_edge_filter_if scl_if ();
    i2c_slave_edge_filter_if sda_if ();

    always #5 clk = ~clk;

    i2c_slave_edge_filter #(
        .SYNC_STAGES (SyncStages),
        .FILTER_LEN  (FilterLen)
    ) u_scl (
        .clk   (clk),
        .reset (reset),
        .bus   (scl_if)
    );

    i2c_slave_edge_filter #(
        .SYNC_STAGES (SyncStages),
        .FILTER_LEN  (FilterLen)
    ) u_sda (
        .clk   (clk),
        .reset (reset),
        .bus   (sda_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cnt_ne [2];
    int cnt_pe [2];

    // Model: the last Lat sampled line values per channel, index 0 oldest.
    // The newest SyncStages samples are still in flight; the oldest FilterLen decide.
    bit m_samp [2][Lat];
    bit m_fsig [2];
    bit m_ne   [2];
    bit m_pe   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < int'(Lat); i++) m_samp[c][i] = 1'b1;
            m_fsig[c] = 1'b1;
            m_ne[c]   = 1'b0;
            m_pe[c]   = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit s_scl, input bit s_sda);
        bit s [2];
        int ones;
        s[0] = s_scl;
        s[1] = s_sda;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < int'(Lat) - 1; i++) m_samp[c][i] = m_samp[c][i+1];
            m_samp[c][Lat-1] = s[c];
            ones = 0;
            for (int i = 0; i < int'(FilterLen); i++) ones += int'(m_samp[c][i]);
            m_ne[c] = 1'b0;
            m_pe[c] = 1'b0;
            if (ones == int'(FilterLen) && !m_fsig[c]) begin
                m_fsig[c] = 1'b1;
                m_pe[c]   = 1'b1;
            end else if (ones == 0 && m_fsig[c]) begin
                m_fsig[c] = 1'b0;
                m_ne[c]   = 1'b1;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_scl_fsig"}, 32'(scl_if.fsig), 32'(m_fsig[0]));
        check({tag, "_scl_ne"},   32'(scl_if.ne),   32'(m_ne[0]));
        check({tag, "_scl_pe"},   32'(scl_if.pe),   32'(m_pe[0]));
        check({tag, "_sda_fsig"}, 32'(sda_if.fsig), 32'(m_fsig[1]));
        check({tag, "_sda_ne"},   32'(sda_if.ne),   32'(m_ne[1]));
        check({tag, "_sda_pe"},   32'(sda_if.pe),   32'(m_pe[1]));
        check({tag, "_mutex"}, 32'((scl_if.ne & scl_if.pe) | (sda_if.ne & sda_if.pe)), 32'd0);
    endtask

    // One clock edge: capture what the edge sees, advance the model, compare after the edge.
    task automatic step(input string tag);
        bit s0, s1, r;
        s0 = scl_if.sig;
        s1 = sda_if.sig;
        r  = reset;
        @(posedge clk);
        #1;
        if (r) model_edge(s0, s1);
        else   model_reset();
        check_outputs(tag);
        cnt_ne[0] += int'(scl_if.ne);
        cnt_pe[0] += int'(scl_if.pe);
        cnt_ne[1] += int'(sda_if.ne);
        cnt_pe[1] += int'(sda_if.pe);
    endtask

    // Edges until the first SDA strobe of the given direction (0 = none within bound).
    task automatic measure(input string tag, input bit rising, output int edges,
                           output logic scl_lvl);
        int i;
        edges   = 0;
        scl_lvl = 1'bx;
        i       = 0;
        while (edges == 0 && i < 20) begin
            i++;
            step(tag);
            if ((rising && sda_if.pe) || (!rising && sda_if.ne)) begin
                edges   = i;
                scl_lvl = scl_if.fsig;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic scl_lvl;
        int   ne0;
        int   pe0;
        int   run0;
        int   run1;

        cnt_ne = '{0, 0};
        cnt_pe = '{0, 0};
        model_reset();

        // T1: reset held with both lines low.
        scl_if.sig = 1'b0;
        sda_if.sig = 1'b0;
        #1 reset = 1'b0;
        #11;
        check_outputs("t1_reset");
        for (int i = 0; i < 3; i++) step("t1_hold");
        reset = 1'b0;
        #1 reset = 1'b1;
        measure("t1_rel", 1'b0, lat, scl_lvl);
        check("t1_ne_latency", 32'(lat), 32'(Lat));
        check("t1_sda_fsig_low", 32'(sda_if.fsig), 32'd0);
        check("t1_no_pe", 32'(cnt_pe[0] + cnt_pe[1]), 32'd0);

        // T2: clean rise then fall; the fall with SCL high is a START, the next rise a STOP.
        scl_if.sig = 1'b1;
        sda_if.sig = 1'b1;
        measure("t2_rise", 1'b1, lat, scl_lvl);
        check("t2_pe_latency", 32'(lat), 32'(Lat));
        step("t2_settle");
        check("t2_pe_one_cycle", 32'(sda_if.pe), 32'd0);
        for (int i = 0; i < 4; i++) step("t2_idle");
        sda_if.sig = 1'b0;
        measure("t5_start", 1'b0, lat, scl_lvl);
        check("t2_ne_latency", 32'(lat), 32'(Lat));
        check("t5_start_scl_high", 32'(scl_lvl), 32'd1);
        step("t2_after_ne");
        check("t2_ne_one_cycle", 32'(sda_if.ne), 32'd0);
        check("t2_fsig_held_low", 32'(sda_if.fsig), 32'd0);
        for (int i = 0; i < 4; i++) step("t2_idle2");
        sda_if.sig = 1'b1;
        measure("t5_stop", 1'b1, lat, scl_lvl);
        check("t5_stop_latency", 32'(lat), 32'(Lat));
        check("t5_stop_scl_high", 32'(scl_lvl), 32'd1);
        for (int i = 0; i < 8; i++) step("t2_idle3");

        // T3: a 3-cycle low pulse is rejected; a 4-cycle one is accepted.
        ne0 = cnt_ne[1];
        pe0 = cnt_pe[1];
        sda_if.sig = 1'b0;
        for (int i = 0; i < 3; i++) step("t3_short");
        sda_if.sig = 1'b1;
        for (int i = 0; i < 12; i++) step("t3_short_tail");
        check("t3_short_ne", 32'(cnt_ne[1] - ne0), 32'd0);
        check("t3_short_pe", 32'(cnt_pe[1] - pe0), 32'd0);
        check("t3_short_fsig", 32'(sda_if.fsig), 32'd1);
        sda_if.sig = 1'b0;
        for (int i = 0; i < 4; i++) step("t3_long");
        sda_if.sig = 1'b1;
        for (int i = 0; i < 14; i++) step("t3_long_tail");
        check("t3_long_ne", 32'(cnt_ne[1] - ne0), 32'd1);
        check("t3_long_pe", 32'(cnt_pe[1] - pe0), 32'd1);

        // T4: toggle every cycle for 20 cycles (ending high), then settle low.
        ne0 = cnt_ne[1];
        pe0 = cnt_pe[1];
        for (int i = 0; i < 20; i++) begin
            sda_if.sig = ~sda_if.sig;
            step("t4_chatter");
        end
        check("t4_chatter_quiet", 32'(cnt_ne[1] + cnt_pe[1] - ne0 - pe0), 32'd0);
        sda_if.sig = 1'b0;
        measure("t4_settle", 1'b0, lat, scl_lvl);
        check("t4_ne_latency", 32'(lat), 32'(Lat));
        for (int i = 0; i < 10; i++) step("t4_tail");
        check("t4_single_ne", 32'(cnt_ne[1] - ne0), 32'd1);
        check("t4_no_pe", 32'(cnt_pe[1] - pe0), 32'd0);

        // Randomised runs on both lines, checked cycle by cycle against the model.
        run0 = 0;
        run1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (run0 == 0) begin
                scl_if.sig = 1'($urandom_range(0, 1));
                run0       = int'($urandom_range(1, 7));
            end
            if (run1 == 0) begin
                sda_if.sig = 1'($urandom_range(0, 1));
                run1       = int'($urandom_range(1, 7));
            end
            run0--;
            run1--;
            step("rand");
        end

        // T6: reset three cycles into a falling transition.
        scl_if.sig = 1'b1;
        sda_if.sig = 1'b1;
        for (int i = 0; i < 10; i++) step("t6_idle");
        sda_if.sig = 1'b0;
        for (int i = 0; i < 3; i++) step("t6_pre");
        reset = 1'b0;
        #1;
        model_reset();
        check("t6_fsig_now", 32'(sda_if.fsig), 32'd1);
        check_outputs("t6_async");
        for (int i = 0; i < 3; i++) step("t6_hold");
        reset = 1'b1;
        pe0 = cnt_pe[1];
        measure("t6_rel", 1'b0, lat, scl_lvl);
        check("t6_ne_latency", 32'(lat), 32'(Lat));
        check("t6_no_pe", 32'(cnt_pe[1] - pe0), 32'd0);
        for (int i = 0; i < 5; i++) step("t6_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
